// File: rtl/sysid_check_master.sv
// Boot-time Avalon-MM read master: reads the sysid ID and timestamp words,
// compares them with expected constants and reports pass/fail, mismatch and
// timeout flags together with the captured words.
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID = 32'd1489966838,
    parameter logic [31:0] EXPECTED_TS = 32'd0,
    parameter bit          CHECK_TS    = 1'b1,
    parameter int unsigned RD_LATENCY  = 0,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {StIdle, StRdId, StLatId, StRdTs, StLatTs, StDone} state_e;

    localparam bit          NoLat      = (RD_LATENCY == 0);
    localparam logic [1:0]  LatLast    = 2'(RD_LATENCY - 1);
    localparam logic [15:0] StallLimit = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [15:0] stall_q, stall_d;
    logic [1:0]  lat_q, lat_d;
    logic        pass_q, pass_d;
    logic        id_mis_q, id_mis_d;
    logic        ts_mis_q, ts_mis_d;
    logic        timeout_q, timeout_d;
    logic [31:0] id_val_q, id_val_d;
    logic [31:0] ts_val_q, ts_val_d;
    logic        cap;
    logic        cap_ts;

    // Next-state logic: sequencing, stall/latency counting, capture and result.
    always_comb begin
        state_d   = state_q;
        stall_d   = stall_q;
        lat_d     = lat_q;
        pass_d    = pass_q;
        id_mis_d  = id_mis_q;
        ts_mis_d  = ts_mis_q;
        timeout_d = timeout_q;
        id_val_d  = id_val_q;
        ts_val_d  = ts_val_q;
        cap       = 1'b0;
        cap_ts    = (state_q == StRdTs) || (state_q == StLatTs);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRdId;
                    stall_d   = '0;
                    pass_d    = 1'b0;
                    id_mis_d  = 1'b0;
                    ts_mis_d  = 1'b0;
                    timeout_d = 1'b0;
                    id_val_d  = '0;
                    ts_val_d  = '0;
                end
            end
            StRdId, StRdTs: begin
                if (!avm_waitrequest) begin
                    if (NoLat) begin
                        cap = 1'b1;
                    end else begin
                        state_d = cap_ts ? StLatTs : StLatId;
                        lat_d   = '0;
                    end
                end else if (stall_q >= StallLimit) begin
                    // Abort: remaining reads are skipped, their values stay 0.
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            StLatId, StLatTs: begin
                if (lat_q == LatLast) begin
                    cap = 1'b1;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (cap) begin
            stall_d = '0;
            if (cap_ts) begin
                ts_val_d = avm_readdata;
                ts_mis_d = CHECK_TS && (avm_readdata != EXPECTED_TS);
                state_d  = StDone;
            end else begin
                id_val_d = avm_readdata;
                id_mis_d = (avm_readdata != EXPECTED_ID);
                state_d  = StRdTs;
            end
        end

        // Result becomes valid in the same cycle as the done pulse.
        if ((state_d == StDone) && (state_q != StDone)) begin
            pass_d = ~id_mis_d & ~ts_mis_d & ~timeout_d;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            stall_q   <= '0;
            lat_q     <= '0;
            pass_q    <= 1'b0;
            id_mis_q  <= 1'b0;
            ts_mis_q  <= 1'b0;
            timeout_q <= 1'b0;
            id_val_q  <= '0;
            ts_val_q  <= '0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            lat_q     <= lat_d;
            pass_q    <= pass_d;
            id_mis_q  <= id_mis_d;
            ts_mis_q  <= ts_mis_d;
            timeout_q <= timeout_d;
            id_val_q  <= id_val_d;
            ts_val_q  <= ts_val_d;
        end
    end

    // Bus and status outputs decoded from state.
    always_comb begin
        avm_read    = (state_q == StRdId) || (state_q == StRdTs);
        avm_address = (state_q == StRdTs) || (state_q == StLatTs);
        busy        = (state_q != StIdle);
        done        = (state_q == StDone);
    end

    assign pass        = pass_q;
    assign id_mismatch = id_mis_q;
    assign ts_mismatch = ts_mis_q;
    assign timeout     = timeout_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;

endmodule
